cal_port_responder: RTL and testbench

//  Responder end of the calc request/response port: samples req_cmd_in/req_data_in,

---
 rtl/cal_pkg.sv | 28 ++
 rtl/cal_alu.sv | 42 ++++
 rtl/cal_port_responder.sv | 109 ++++++++++
 tb/tb_cal_port_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared types and constants for the calc request/response port responder.
package cal_pkg;

  localparam int CAL_DW = 32;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cal_cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_BAD  = 2'd3
  } cal_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } cal_state_e;

endpackage

// File: rtl/cal_alu.sv
// Combinational calculator core: result plus overflow/underflow and invalid-command flags.
module cal_alu
  import cal_pkg::*;
#(
  parameter int DW = CAL_DW
) (
  input  logic [3:0]    cmd_i,
  input  logic [0:DW-1] op1_i,
  input  logic [0:DW-1] op2_i,
  output logic [0:DW-1] result_o,
  output logic          ovf_o,
  output logic          bad_o
);

  logic [DW:0] sum;
  logic [4:0]  shamt;

  assign sum   = {1'b0, op1_i} + {1'b0, op2_i};
  // Bit 0 is the MSB, so the low five bits of op2 sit at the right-hand end.
  assign shamt = op2_i[DW-5:DW-1];

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    bad_o    = 1'b0;
    case (cmd_i)
      CMD_ADD: begin
        result_o = sum[DW-1:0];
        ovf_o    = sum[DW];
      end
      CMD_SUB: begin
        result_o = op1_i - op2_i;
        ovf_o    = (op1_i < op2_i);
      end
      CMD_SHL: result_o = op1_i << shamt;
      CMD_SHR: result_o = op1_i >> shamt;
      default: bad_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cal_port_responder.sv
// Responder end of one calc port: take cmd+op1 then op2, wait LATENCY cycles, emit one beat.
// Define CAL_OVF_CHECK_EN to report overflow/underflow as resp 2 instead of a wrapped result.
module cal_port_responder
  import cal_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DW      = CAL_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    req_cmd_in,
  input  logic [0:DW-1] req_data_in,
  output logic [1:0]    out_resp,
  output logic [0:DW-1] out_data,
  output logic          prot_err
);

`ifdef CAL_OVF_CHECK_EN
  localparam bit OVF_CHECK = 1'b1;
`else
  localparam bit OVF_CHECK = 1'b0;
`endif

  cal_state_e    state_q, state_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          prot_err_q, prot_err_d;
  logic [0:DW-1] op1_q, op1_d, op2_q, op2_d;

  logic [0:DW-1] alu_result;
  logic          alu_ovf, alu_bad;

  cal_alu #(.DW(DW)) u_alu (
    .cmd_i   (cmd_q),
    .op1_i   (op1_q),
    .op2_i   (op2_q),
    .result_o(alu_result),
    .ovf_o   (alu_ovf),
    .bad_o   (alu_bad)
  );

  // NOTE: next-state logic uses blocking '=' in always_comb; registers below use non-blocking '<='.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    prot_err_d = prot_err_q | ((state_q != ST_IDLE) && (req_cmd_in != 4'd0));
    case (state_q)
      ST_IDLE: begin
        if (req_cmd_in != 4'd0) begin
          cmd_d   = req_cmd_in;
          op1_d   = req_data_in;
          state_d = ST_OP2;
        end
      end
      ST_OP2: begin
        op2_d   = req_data_in;
        cnt_d   = 4'(LATENCY - 1);
        state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        // Leave as the count reaches zero so the beat lands LATENCY+1 cycles after the cmd.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 4'd0;
      cnt_q      <= 4'd0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      prot_err_q <= prot_err_d;
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded before the ALU result is used.
  always_ff @(posedge clk) begin
    op1_q <= op1_d;
    op2_q <= op2_d;
  end

  always_comb begin
    out_resp = RESP_NONE;
    out_data = '0;
    if (state_q == ST_RESP) begin
      if (alu_bad) begin
        out_resp = RESP_BAD;
      end else if (alu_ovf && OVF_CHECK) begin
        out_resp = RESP_OVF;
      end else begin
        out_resp = RESP_OK;
        out_data = alu_result;
      end
    end
  end

  assign prot_err = prot_err_q;

endmodule

// File: tb/tb_cal_port_responder.sv
// Scoreboard bench for cal_port_responder: expected beats queued at issue, compared on output.
module tb_cal_port_responder;

  localparam int LAT = 3;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_cmd_in;
  logic [0:DW-1] req_data_in;
  logic [1:0]    out_resp;
  logic [0:DW-1] out_data;
  logic          prot_err;

  typedef struct {
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cal_port_responder #(.LATENCY(LAT), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .prot_err   (prot_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Reference behaviour: {resp, data}
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic        ovf;
    bit          ovf_en;
`ifdef CAL_OVF_CHECK_EN
    ovf_en = 1'b1;
`else
    ovf_en = 1'b0;
`endif
    ovf = 1'b0;
    r   = 32'h0;
    case (c)
      4'd1: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; ovf = wide[32]; end
      4'd2: begin r = a - b; ovf = (b > a); end
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      default: return {2'd3, 32'h0};
    endcase
    if (ovf && ovf_en) return {2'd2, 32'h0};
    return {2'd1, r};
  endfunction

  // Drives one request; returns so the next issue lands in the cycle after RESP.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input bit intrude);
    exp_t        e;
    logic [33:0] m;
    @(posedge clk); #1;
    req_cmd_in  = c;
    req_data_in = a;
    m      = model(c, a, b);
    e.cyc  = cyc + LAT + 1;
    e.resp = m[33:32];
    e.data = m[31:0];
    sb.push_back(e);
    @(posedge clk); #1;
    req_cmd_in  = 4'd0;
    req_data_in = b;
    if (intrude) begin
      @(posedge clk); #1;
      req_cmd_in  = 4'd1;
      req_data_in = $urandom;
      @(posedge clk); #1;
      req_cmd_in  = 4'd0;
      req_data_in = '0;
      repeat (LAT - 2) @(posedge clk);
    end else begin
      repeat (LAT) @(posedge clk);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("resp", out_resp, e.resp);
        check("data", out_data, e.data);
      end else begin
        check("idle_resp", out_resp, 2'd0);
        check("idle_data", out_data, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] cmds [5];
    cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd9};
    reset       = 1'b0;
    req_cmd_in  = 4'd0;
    req_data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp", out_resp, 2'd0);
    check("rst_data", out_data, 32'h0);
    check("rst_prot_err", prot_err, 1'b0);
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    issue(4'd1, 32'h0000_0005, 32'h0000_0003, 1'b0);
    issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    issue(4'd2, 32'h0000_0002, 32'h0000_0003, 1'b0);
    issue(4'd2, 32'h0000_0009, 32'h0000_0004, 1'b0);
    issue(4'd5, 32'h0000_0001, 32'h0000_0024, 1'b0);
    issue(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    for (int i = 0; i < 8; i++)
      issue(cmds[$urandom_range(0, 4)], $urandom, $urandom, 1'b0);
    @(negedge clk);
    check("prot_err_clean", prot_err, 1'b0);

    issue(4'd1, 32'h0000_0005, 32'h0000_0003, 1'b1);
    @(negedge clk);
    check("prot_err_set", prot_err, 1'b1);
    issue(4'd2, 32'h0000_0010, 32'h0000_0001, 1'b0);
    @(negedge clk);
    check("prot_err_sticky", prot_err, 1'b1);

    // Reset during WAIT: no beat must appear, prot_err clears.
    @(posedge clk); #1;
    req_cmd_in  = 4'd1;
    req_data_in = 32'h0000_0007;
    @(posedge clk); #1;
    req_cmd_in  = 4'd0;
    req_data_in = 32'h0000_0009;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_prot_err", prot_err, 1'b0);
    repeat (4) @(posedge clk);

    issue(4'd1, 32'h0000_0001, 32'h0000_0001, 1'b0);
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
